// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: 8x8 unsigned multiply and 8/8 unsigned restoring divide,
// one iteration per cycle, borrowing the shared combinational ALU through
// a request/grant pair. Results and div_zero are held between operations.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; ALU bus parked at zero
// CALC  | iterating; one step per edge with alu_gnt high (8 steps)
// DONE  | one-cycle done pulse, results valid
module alu_muldiv_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       op_div,
    input  logic [7:0] opa,
    input  logic [7:0] opb,
    output logic       busy,
    output logic       done,
    output logic [7:0] result_hi,
    output logic [7:0] result_lo,
    output logic       div_zero,
    output logic       alu_req,
    input  logic       alu_gnt,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_op,
    input  logic [7:0] alu_result,
    input  logic       alu_carry
);

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h3;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t     state_q, state_d;
    logic [7:0] hi_q, hi_d;
    logic [7:0] lo_q, lo_d;
    logic [7:0] m_q, m_d;
    logic [2:0] cnt_q, cnt_d;
    logic       mode_q, mode_d;
    logic [7:0] res_hi_q, res_hi_d;
    logic [7:0] res_lo_q, res_lo_d;
    logic       dz_q, dz_d;

    // Iteration helpers: multiply shift-add sum and divide shifted remainder.
    logic [8:0] sum9;
    logic [7:0] rs;
    logic       q_bit;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q     <= 8'h00;
            lo_q     <= 8'h00;
            m_q      <= 8'h00;
            cnt_q    <= 3'd0;
            mode_q   <= 1'b0;
            res_hi_q <= 8'h00;
            res_lo_q <= 8'h00;
            dz_q     <= 1'b0;
        end else begin
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            m_q      <= m_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            dz_q     <= dz_d;
        end
    end

    // Next-state and next-datapath logic; an iteration only advances on grant.
    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        dz_d     = dz_q;
        // The NOP result is never used: a zero multiplier bit keeps hi as-is.
        sum9     = lo_q[0] ? {alu_carry, alu_result} : {1'b0, hi_q};
        rs       = {hi_q[6:0], lo_q[7]};
        // A set msb means the true 9-bit partial remainder already exceeds m.
        q_bit    = hi_q[7] | ~alu_carry;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d = op_div;
                    m_d    = opb;
                    hi_d   = 8'h00;
                    lo_d   = opa;
                    cnt_d  = 3'd0;
                    dz_d   = 1'b0;
                    if (op_div && (opb == 8'h00)) begin
                        res_hi_d = opa;
                        res_lo_d = 8'hFF;
                        dz_d     = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (alu_gnt) begin
                    if (mode_q) begin
                        hi_d = q_bit ? alu_result : rs;
                        lo_d = {lo_q[6:0], q_bit};
                    end else begin
                        hi_d = sum9[8:1];
                        lo_d = {sum9[0], lo_q[7:1]};
                    end
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        res_hi_d = hi_d;
                        res_lo_d = lo_d;
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: handshake flags and the ALU bus, parked at zero outside CALC.
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        alu_req = 1'b0;
        alu_a   = 8'h00;
        alu_b   = 8'h00;
        alu_op  = OP_NOP;
        case (state_q)
            S_CALC: begin
                busy    = 1'b1;
                alu_req = 1'b1;
                alu_b   = m_q;
                if (mode_q) begin
                    alu_a  = rs;
                    alu_op = OP_SUB;
                end else begin
                    alu_a  = hi_q;
                    alu_op = lo_q[0] ? OP_ADD : OP_NOP;
                end
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign result_hi = res_hi_q;
    assign result_lo = res_lo_q;
    assign div_zero  = dz_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: combinational ALU model, arithmetic reference
// (a*b, a/b, a%b), directed literal cases and randomized operations.
module tb_alu_muldiv_seq;

    logic       clk = 1'b0;
    logic       rst, start, op_div;
    logic [7:0] opa, opb;
    logic       busy, done, div_zero, alu_req, alu_gnt, alu_carry;
    logic [7:0] result_hi, result_lo, alu_a, alu_b, alu_result;
    logic [3:0] alu_op;
    logic [8:0] alu_sum;

    int errors = 0;
    int checks = 0;

    // Expected outputs of the operation in flight and of the last completed one.
    logic [7:0] pend_hi, pend_lo;
    logic       pend_dz;
    logic [7:0] held_hi = 8'h00, held_lo = 8'h00;
    logic       held_dz = 1'b0;
    bit         op_live = 1'b0;
    bit         cur_div = 1'b0;

    alu_muldiv_seq dut (
        .clk(clk), .rst(rst), .start(start), .op_div(op_div),
        .opa(opa), .opb(opb), .busy(busy), .done(done),
        .result_hi(result_hi), .result_lo(result_lo), .div_zero(div_zero),
        .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .alu_result(alu_result), .alu_carry(alu_carry)
    );

    always #5 clk = ~clk;

    // Shared ALU: ADD with carry-out, SUBTRACT with borrow; NOP yields junk.
    always_comb begin
        case (alu_op)
            4'h1:    alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
            4'h3:    alu_sum = {(alu_a < alu_b), alu_a - alu_b};
            default: alu_sum = 9'h1C3;
        endcase
    end
    assign alu_result = alu_sum[7:0];
    assign alu_carry  = alu_sum[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the reference model.
    always @(negedge clk) begin
        if (rst) begin
            held_hi = 8'h00; held_lo = 8'h00; held_dz = 1'b0; op_live = 1'b0;
        end else begin
            chk("busy_done_excl", 64'(busy & done), 64'd0);
            chk("alu_req_eq_busy", 64'(alu_req), 64'(busy));
            if (!busy) chk("alu_bus_idle", {44'd0, alu_a, alu_b, alu_op}, 64'd0);
            else if (cur_div) chk("div_alu_op", 64'(alu_op), 64'd3);
            else chk("mul_alu_op", 64'(alu_op[3:1]), 64'd0);
            if (done) begin
                chk("done_expected", 64'(op_live), 64'd1);
                chk("result", {47'd0, div_zero, result_hi, result_lo},
                    {47'd0, pend_dz, pend_hi, pend_lo});
                held_hi = pend_hi; held_lo = pend_lo; held_dz = pend_dz;
                op_live = 1'b0;
            end else begin
                chk("result_hold", {48'd0, result_hi, result_lo}, {48'd0, held_hi, held_lo});
                chk("div_zero_hold", 64'(div_zero), busy ? 64'd0 : 64'(held_dz));
            end
        end
    end

    // gmode: 0 grant tied high, 1 grant low for 3 mid-CALC cycles, 2 random.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit div,
                          input int gmode, input bit inject,
                          input bit has_lit, input logic [16:0] lit);
        int n;
        int stalls;
        bit g;
        @(posedge clk); #1;
        start = 1'b1; opa = a; opb = b; op_div = div; cur_div = div;
        if (div && b == 8'h00) begin
            pend_dz = 1'b1; pend_hi = a; pend_lo = 8'hFF;
        end else if (div) begin
            pend_dz = 1'b0; pend_hi = a % b; pend_lo = a / b;
        end else begin
            pend_dz = 1'b0; {pend_hi, pend_lo} = 16'(a) * 16'(b);
        end
        op_live = 1'b1;
        stalls = 0;
        @(posedge clk); #1;
        n = 1;
        opa = 8'($urandom); opb = 8'($urandom); op_div = 1'($urandom_range(0, 1));
        while (!done && n < 60) begin
            start = (inject && n == 3);
            chk("busy_in_calc", 64'(busy), 64'd1);
            if (gmode == 0)      g = 1'b1;
            else if (gmode == 1) g = !(n >= 4 && n <= 6);
            else                 g = ($urandom_range(0, 3) != 0);
            alu_gnt = g;
            if (!g) stalls++;
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        alu_gnt = 1'b1;
        chk("latency", 64'(n), (div && b == 8'h00) ? 64'd1 : 64'(9 + stalls));
        if (has_lit) chk("literal", {47'd0, div_zero, result_hi, result_lo}, {47'd0, lit});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op_div = 1'b0; opa = 8'h00; opb = 8'h00; alu_gnt = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_state", {25'd0, busy, done, alu_req, div_zero, result_hi, result_lo,
                            alu_a, alu_b, alu_op}, 64'd0);

        run_op(8'd13,  8'd11,  1'b0, 0, 1'b0, 1'b1, {1'b0, 16'h008F});
        run_op(8'hFF,  8'hFF,  1'b0, 0, 1'b0, 1'b1, {1'b0, 16'hFE01});
        run_op(8'h00,  8'h37,  1'b0, 0, 1'b0, 1'b1, {1'b0, 16'h0000});
        run_op(8'd200, 8'd7,   1'b1, 0, 1'b0, 1'b1, {1'b0, 8'h04, 8'h1C});
        run_op(8'hFF,  8'h80,  1'b1, 0, 1'b0, 1'b1, {1'b0, 8'h7F, 8'h01});
        run_op(8'h5A,  8'h00,  1'b1, 0, 1'b0, 1'b1, {1'b1, 8'h5A, 8'hFF});
        run_op(8'd13,  8'd11,  1'b0, 1, 1'b0, 1'b1, {1'b0, 16'h008F});
        run_op(8'd13,  8'd11,  1'b0, 0, 1'b1, 1'b1, {1'b0, 16'h008F});

        // Abort at iteration 4: everything returns to reset values, no done.
        @(posedge clk); #1;
        start = 1'b1; opa = 8'd13; opb = 8'd11; op_div = 1'b0; cur_div = 1'b0;
        pend_dz = 1'b0; pend_hi = 8'h00; pend_lo = 8'h8F; op_live = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("reset_abort", {25'd0, busy, done, alu_req, div_zero, result_hi, result_lo,
                            alu_a, alu_b, alu_op}, 64'd0);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            chk("no_done_after_abort", 64'(done), 64'd0);
        end

        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            run_op(ra, rb, 1'($urandom_range(0, 1)), 2, 1'($urandom_range(0, 1)),
                   1'b0, 17'd0);
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
